decoder_scan_ctrl: RTL and testbench

Address sequencer that drives the select input and enable of the 4x16 decoder. On a start request it steps the 4-bit address through every unmasked index, 0 up to 15, and holds each one for a programmable dwell time with enable asserted. It supports a single sweep or a continuous sweep. It sits directly upstream of the decoder: its `a`/`en` outputs connect straight to the decoder's `a`/`en` inputs.

---
 rtl/decoder_scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_decoder_scan_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_ctrl.sv
// Address sequencer for a 4x16 decoder: sweeps unmasked addresses with a dwell time.
// Optional break-before-make gap cycle between addresses when SCAN_GAP_EN is defined.
module decoder_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic        stop,
  input  logic [15:0] skip_mask,
  output logic [3:0]  a,
  output logic        en,
  output logic        busy,
  output logic        done,
  output logic        wrap
);

`ifdef SCAN_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, GAP = 2'd2, FIN = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FIN = 2'd3} state_t;
`endif

  localparam int DWELL_EFF = (DWELL < 1) ? 1 : DWELL;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_EFF - 1);

  state_t            state_reg, state_next;
  logic [3:0]        a_reg, a_next;
  logic              en_reg, en_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              wrap_reg, wrap_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              mode_reg, mode_next;
  logic [15:0]       mask_reg, mask_next;

  // Returns {found, index} of the lowest set bit.
  function automatic logic [4:0] lowest_set(input logic [15:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  logic [16:0] above_sh;
  logic [15:0] above;
  logic [4:0]  first_in, first_lat, next_up;

  // Bits strictly above the current address.
  assign above_sh  = 17'h1FFFF << ({1'b0, a_reg} + 5'd1);
  assign above     = above_sh[15:0];
  assign first_in  = lowest_set(~skip_mask);
  assign first_lat = lowest_set(~mask_reg);
  assign next_up   = lowest_set(~mask_reg & above);

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    en_next    = 1'b0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    wrap_next  = 1'b0;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    mask_next  = mask_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          mode_next = mode;
          mask_next = skip_mask;
          cnt_next  = '0;
          if (first_in[4]) begin
            state_next = SCAN;
            a_next     = first_in[3:0];
            en_next    = 1'b1;
            busy_next  = 1'b1;
          end else begin
            state_next = FIN;
            done_next  = 1'b1;
          end
        end
      end
      SCAN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (cnt_reg != DWELL_LAST) begin
          cnt_next  = cnt_reg + 1'b1;
          en_next   = 1'b1;
          busy_next = 1'b1;
        end else begin
          cnt_next = '0;
          if (next_up[4] || (mode_reg && first_lat[4])) begin
`ifdef SCAN_GAP_EN
            // Address moves when leaving GAP, so the decoder sees en low first.
            state_next = GAP;
            busy_next  = 1'b1;
`else
            en_next   = 1'b1;
            busy_next = 1'b1;
            if (next_up[4]) begin
              a_next = next_up[3:0];
            end else begin
              a_next    = first_lat[3:0];
              wrap_next = 1'b1;
            end
`endif
          end else begin
            state_next = FIN;
            done_next  = 1'b1;
          end
        end
      end
`ifdef SCAN_GAP_EN
      GAP: begin
        if (stop) begin
          state_next = IDLE;
        end else begin
          state_next = SCAN;
          cnt_next   = '0;
          en_next    = 1'b1;
          busy_next  = 1'b1;
          if (next_up[4]) begin
            a_next = next_up[3:0];
          end else begin
            a_next    = first_lat[3:0];
            wrap_next = 1'b1;
          end
        end
      end
`endif
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      en_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
      cnt_reg   <= '0;
      mode_reg  <= 1'b0;
      mask_reg  <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      en_reg    <= en_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      wrap_reg  <= wrap_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
      mask_reg  <= mask_next;
    end
  end

  assign a    = a_reg;
  assign en   = en_reg;
  assign busy = busy_reg;
  assign done = done_reg;
  assign wrap = wrap_reg;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Self-checking bench for decoder_scan_ctrl: table of single sweeps plus
// continuous/stop and reset sequences. Outputs sampled on the falling edge.
module tb_decoder_scan_ctrl;
  localparam int DW = 4;
`ifdef SCAN_GAP_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, mode, stop;
  logic [15:0] skip_mask;
  logic [3:0]  a;
  logic        en, busy, done, wrap;

  always #5 clk = ~clk;

  decoder_scan_ctrl #(.DWELL(DW), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .stop(stop),
    .skip_mask(skip_mask), .a(a), .en(en), .busy(busy), .done(done), .wrap(wrap)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] mask;
    int          n;
    int          first;
    int          last;
    int          done_at;
    bit          disturb;
  } vec_t;

  vec_t vecs[7];

  task automatic run_single(input vec_t v);
    int list[16];
    int nl = 0;
    int en_cnt = 0, busy_cnt = 0, done_at = -1, first_en = -1;
    int first_a = -1, last_a = -1, seq_bad = 0;
    for (int i = 0; i < 16; i++) if (!v.mask[i]) begin list[nl] = i; nl++; end
    @(negedge clk);
    start = 1'b1; mode = 1'b0; skip_mask = v.mask;
    @(negedge clk);
    start = 1'b0;
    for (int t = 1; t <= 200; t++) begin
      if (t > 1) @(negedge clk);
      if (v.disturb) begin
        if (t >= 6 && t <= 12) begin
          start = 1'b1; mode = 1'b1; skip_mask = ~v.mask;
        end else begin
          start = 1'b0; mode = 1'b0; skip_mask = v.mask;
        end
      end
      if (busy) busy_cnt++;
      if (wrap) seq_bad++;
      if (en) begin
        if (first_en < 0) begin first_en = t; first_a = int'(a); end
        last_a = int'(a);
        if (en_cnt / DW >= nl || int'(a) != list[en_cnt / DW]) seq_bad++;
        en_cnt++;
      end
      if (done) begin
        done_at = t;
        chk("done_en", int'(en), 0);
        chk("done_busy", int'(busy), 0);
        break;
      end
    end
    start = 1'b0; mode = 1'b0; skip_mask = v.mask;
    chk("done_at", done_at, v.done_at);
    chk("en_cycles", en_cnt, v.n * DW);
    chk("busy_cycles", busy_cnt, (v.n > 0) ? v.n * DW + (v.n - 1) * G : 0);
    chk("first_en_t", first_en, (v.n > 0) ? 1 : -1);
    chk("first_addr", first_a, v.first);
    chk("last_addr", last_a, v.last);
    chk("addr_seq", seq_bad, 0);
    @(negedge clk);
    chk("done_pulse", int'(done), 0);
    $display("single sweep mask=%h disturb=%0d en_cycles=%0d done_at=%0d", v.mask, v.disturb, en_cnt, done_at);
  endtask

  task automatic run_cont(input int stop_e);
    int e = 0, wraps = 0, seq_bad = 0, reached = 0;
    logic [3:0] a_hold;
    a_hold = 4'd0;
    @(negedge clk);
    start = 1'b1; mode = 1'b1; skip_mask = 16'hFFF0;
    @(negedge clk);
    start = 1'b0; mode = 1'b0;
    for (int t = 1; t <= 400; t++) begin
      if (t > 1) @(negedge clk);
      if (done) seq_bad++;
      if (wrap) begin
        if (en && e % 16 == 0 && e > 0) wraps++;
        else seq_bad++;
      end
      if (en) begin
        if (int'(a) != (e / DW) % 4) seq_bad++;
        if (e == stop_e) begin
          a_hold = a; stop = 1'b1; reached = 1;
          break;
        end
        e++;
      end
    end
    chk("cont_reached_stop", reached, 1);
    @(negedge clk);
    stop = 1'b0;
    chk("stop_en", int'(en), 0);
    chk("stop_busy", int'(busy), 0);
    chk("stop_done", int'(done), 0);
    chk("stop_wrap", int'(wrap), 0);
    chk("stop_a_hold", int'(a), int'(a_hold));
    repeat (4) begin
      @(negedge clk);
      if (en || busy || done || wrap) seq_bad++;
    end
    chk("cont_seq", seq_bad, 0);
    chk("cont_wraps", wraps, stop_e / 16);
    $display("continuous sweep stop_at=%0d wraps=%0d a_at_stop=%0d", stop_e, wraps, a_hold);
  endtask

  initial begin
    vecs[0] = '{16'h0000, 16, 0, 15, 65 + 15 * G, 1'b0};
    vecs[1] = '{16'hAAAA, 8, 0, 14, 33 + 7 * G, 1'b0};
    vecs[2] = '{16'hFFFF, 0, -1, -1, 1, 1'b0};
    vecs[3] = '{16'h7FFF, 1, 15, 15, 5, 1'b0};
    vecs[4] = '{16'hFFFE, 1, 0, 0, 5, 1'b0};
    vecs[5] = '{16'h5555, 8, 1, 15, 33 + 7 * G, 1'b0};
    vecs[6] = '{16'hAAAA, 8, 0, 14, 33 + 7 * G, 1'b1};

    rst = 1'b1; start = 1'b0; mode = 1'b0; stop = 1'b0; skip_mask = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_a", int'(a), 0);
    chk("reset_en", int'(en), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_wrap", int'(wrap), 0);
    $display("reset applied a=%0d en=%0d busy=%0d", a, en, busy);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_single(vecs[i]);

    run_cont(21);
    run_cont(47);

    // Reset while the third address is on the decoder.
    begin
      int en_cnt = 0;
      int hit = 0;
      @(negedge clk);
      start = 1'b1; mode = 1'b0; skip_mask = 16'h0000;
      @(negedge clk);
      start = 1'b0;
      for (int t = 1; t <= 100; t++) begin
        if (t > 1) @(negedge clk);
        if (en) en_cnt++;
        if (en_cnt == 10) begin
          hit = int'(a);
          rst = 1'b1;
          break;
        end
      end
      chk("mid_reset_addr_before", hit, 2);
      @(negedge clk);
      rst = 1'b0;
      chk("mid_reset_a", int'(a), 0);
      chk("mid_reset_en", int'(en), 0);
      chk("mid_reset_busy", int'(busy), 0);
      chk("mid_reset_done", int'(done), 0);
      chk("mid_reset_wrap", int'(wrap), 0);
      $display("reset during third address a_before=%0d a_after=%0d", hit, a);
    end
    run_single(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
